// File: rtl/seven_segment_scanner.sv
// Time-multiplexed hex driver for an N-digit seven-segment bank: one shared decoder,
// per-digit decimal points, leading-zero blanking and tear-free frame-boundary updates.
module seven_segment_scanner #(
    parameter int NUM_DIGITS    = 4,
    parameter int SCAN_DIV      = 50000,
    parameter int ACTIVE_LOW    = 1,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF   = (ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [PRE_W-1:0]        presc;
    logic [IDX_W-1:0]        idx;
    logic                    boundary;
    logic [4*NUM_DIGITS-1:0] shadow, disp, upper;
    logic [NUM_DIGITS-1:0]   shadow_dp, disp_dp, an_hot, an_next;
    logic                    pending, blank, dp_lit, dp_next;
    logic [3:0]              nib;
    logic [6:0]              seg_low, seg_next;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    assign boundary = (presc == PRE_LAST) && (idx == IDX_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRE_LAST) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // The display register is written only on the last cycle of a frame, so a
    // frame is always drawn from one consistent value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow    <= '0;
            shadow_dp <= '0;
            disp      <= '0;
            disp_dp   <= '0;
            pending   <= 1'b0;
        end else if (boundary) begin
            if (load) begin
                disp    <= value_in;
                disp_dp <= dp_in;
            end else if (pending) begin
                disp    <= shadow;
                disp_dp <= shadow_dp;
            end
            pending <= 1'b0;
        end else if (load) begin
            shadow    <= value_in;
            shadow_dp <= dp_in;
            pending   <= 1'b1;
        end
    end

    always_comb begin
        an_hot   = NUM_DIGITS'(1) << idx;
        upper    = disp >> {idx, 2'b00};
        nib      = upper[3:0];
        blank    = (BLANK_LEADING != 0) && (idx != '0) && (upper == '0);
        seg_low  = blank ? 7'h7F : decode(nib);
        dp_lit   = |(disp_dp & an_hot);
        seg_next = (ACTIVE_LOW != 0) ? seg_low : ~seg_low;
        dp_next  = (ACTIVE_LOW != 0) ? ~dp_lit : dp_lit;
        an_next  = (ACTIVE_LOW != 0) ? ~an_hot : an_hot;
    end

    // NOTE: pins are registered so they never glitch; reset parks them at the off level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            an         <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_next;
            dp         <= dp_next;
            an         <= an_next;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner (4 digits, 4-cycle slots, active-low, blanking on),
// checked against a frame-position model plus directed literal expectations.
module tb_seven_segment_scanner;

    localparam int N = 4;
    localparam int S = 4;
    localparam int F = N * S;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    // Model state: edges since reset, displayed value, shadow value, pending flag.
    int          m_cyc;
    logic [15:0] m_disp, m_sh;
    logic [3:0]  m_dp, m_sh_dp;
    logic        m_pend;
    int          step_no = 0;

    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [6:0] a5_seg [4] = '{7'h12, 7'h08, 7'h7F, 7'h7F};
    logic [6:0] n1234_seg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic [3:0] an_slot [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    seven_segment_scanner #(
        .NUM_DIGITS(N), .SCAN_DIV(S), .ACTIVE_LOW(1), .BLANK_LEADING(1)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .value_in(value_in), .dp_in(dp_in),
        .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int d, input logic [15:0] v);
        logic [15:0] up;
        up = v >> (4 * d);
        if (d > 0 && up == 16'h0) return 7'h7F;
        return tbl[up[3:0]];
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_disp = '0; m_sh = '0; m_dp = '0; m_sh_dp = '0; m_pend = 1'b0;
    endtask

    // One clock: drive inputs, predict the registered outputs, compare after the edge.
    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d);
        int p, dig;
        logic bnd;
        logic [6:0] e_seg;
        logic [3:0] e_an;
        logic e_dp;
        load = ld; value_in = v; dp_in = d;
        @(posedge clk);
        p     = m_cyc % F;
        dig   = p / S;
        bnd   = (p == F - 1);
        e_seg = exp_seg(dig, m_disp);
        e_an  = ~(4'b0001 << dig);
        e_dp  = ~m_dp[dig];
        if (bnd) begin
            if (ld) begin m_disp = v; m_dp = d; end
            else if (m_pend) begin m_disp = m_sh; m_dp = m_sh_dp; end
            m_pend = 1'b0;
        end else if (ld) begin
            m_sh = v; m_sh_dp = d; m_pend = 1'b1;
        end
        m_cyc++;
        step_no++;
        @(negedge clk);
        chk("seg", 32'(seg), 32'(e_seg));
        chk("an", 32'(an), 32'(e_an));
        chk("dp", 32'(dp), 32'(e_dp));
        chk("frame_done", 32'(frame_done), 32'(bnd));
    endtask

    task automatic run_to(input int target);
        while (m_cyc % F != target) step(1'b0, 16'h0, 4'h0);
    endtask

    initial begin
        int slot, last_pulse, pulses;
        logic [15:0] v;
        rst = 1'b1; load = 1'b0; value_in = '0; dp_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_an", 32'(an), 32'hF);
        chk("reset_dp", 32'(dp), 32'h1);
        chk("reset_fd", 32'(frame_done), 32'h0);
        rst = 1'b0;

        // 1: A5 shows after the next boundary, blanked upper digits, 4-cycle slots.
        step(1'b1, 16'h00A5, 4'h0);
        run_to(0);
        for (int i = 0; i < F; i++) begin
            step(1'b0, 16'h0, 4'h0);
            chk("t1_seg", 32'(seg), 32'(a5_seg[i / S]));
            chk("t1_an", 32'(an), 32'(an_slot[i / S]));
        end

        // 2: mid-frame load does not tear the current frame.
        repeat (5) step(1'b0, 16'h0, 4'h0);
        step(1'b1, 16'h1234, 4'h0);
        while (m_cyc % F != 0) begin
            slot = (m_cyc % F) / S;
            step(1'b0, 16'h0, 4'h0);
            chk("t2_old", 32'(seg), 32'(a5_seg[slot]));
        end
        for (int i = 0; i < F; i++) begin
            step(1'b0, 16'h0, 4'h0);
            chk("t2_new", 32'(seg), 32'(n1234_seg[i / S]));
        end

        // 3: zero value with a lit dp on digit 2.
        step(1'b1, 16'h0000, 4'b0100);
        run_to(0);
        for (int i = 0; i < F; i++) begin
            step(1'b0, 16'h0, 4'h0);
            chk("t3_seg", 32'(seg), (i / S == 0) ? 32'h40 : 32'h7F);
            chk("t3_dp", 32'(dp), (an == 4'b1011) ? 32'h0 : 32'h1);
        end

        // 4: load on the boundary cycle goes straight to display.
        run_to(F - 1);
        step(1'b1, 16'hFFFF, 4'h0);
        chk("t4_pending", 32'(dut.pending), 32'h0);
        for (int i = 0; i < F; i++) begin
            step(1'b0, 16'h0, 4'h0);
            chk("t4_seg", 32'(seg), 32'h0E);
        end

        // 5: three frames give three pulses 16 cycles apart.
        last_pulse = -1;
        pulses = 0;
        for (int i = 0; i < 3 * F; i++) begin
            step(1'b0, 16'h0, 4'h0);
            if (frame_done) begin
                pulses++;
                if (last_pulse >= 0) chk("t5_spacing", 32'(step_no - last_pulse), 32'(F));
                last_pulse = step_no;
            end
        end
        chk("t5_pulses", 32'(pulses), 32'd3);

        // Random loads with varied leading-zero counts and dp patterns.
        for (int i = 0; i < 400; i++) begin
            v = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
            step(($urandom_range(0, 7) == 0), v, 4'($urandom));
        end

        // 6: async reset between edges, then digit 0 shows "0".
        run_to(6);
        #2 rst = 1'b1;
        #1;
        chk("t6_an", 32'(an), 32'hF);
        chk("t6_seg", 32'(seg), 32'h7F);
        chk("t6_dp", 32'(dp), 32'h1);
        chk("t6_fd", 32'(frame_done), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 16'h0, 4'h0);
        chk("t6_digit0", 32'(seg), 32'h40);
        chk("t6_an0", 32'(an), 32'hE);
        repeat (2 * F) step(1'b0, 16'h0, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
